// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table checker: walks every input vector through a combinational DUT,
// samples its output at the end of each dwell and compares the captured table to an expected one.
module truth_table_sweeper #(
    parameter int N_IN  = 3,
    parameter int DWELL = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2**N_IN-1:0]   expected,
    input  logic                 dut_y,
    output logic [N_IN-1:0]      vec,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2**N_IN-1:0]   table_out,
    output logic [N_IN:0]        mismatch_cnt,
    output logic                 err_valid,
    output logic [N_IN-1:0]      first_err
);

    localparam int NV = 2**N_IN;
    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_next;
    logic [7:0]      dwell_cnt;
    logic [NV-1:0]   exp_q;
    logic            sample;
    logic            last_vec;
    logic            mis_now;

    always_comb begin
        state_next = state;
        sample     = 1'b0;
        last_vec   = (vec == {N_IN{1'b1}});
        mis_now    = (dut_y != exp_q[vec]);
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                sample = (dwell_cnt == DWELL_LAST);
                if (abort)                    state_next = IDLE;
                else if (sample && last_vec)  state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            table_out    <= '0;
            mismatch_cnt <= '0;
            err_valid    <= 1'b0;
            first_err    <= '0;
            dwell_cnt    <= '0;
            exp_q        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        exp_q        <= expected;
                        table_out    <= '0;
                        mismatch_cnt <= '0;
                        err_valid    <= 1'b0;
                        first_err    <= '0;
                        pass         <= 1'b0;
                        vec          <= '0;
                        dwell_cnt    <= '0;
                        busy         <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        // partial results stay visible; pass is forced low so they are not trusted
                        busy      <= 1'b0;
                        vec       <= '0;
                        pass      <= 1'b0;
                        dwell_cnt <= '0;
                    end else if (sample) begin
                        table_out[vec] <= dut_y;
                        if (mis_now) begin
                            mismatch_cnt <= mismatch_cnt + (N_IN+1)'(1);
                            if (!err_valid) begin
                                first_err <= vec;
                                err_valid <= 1'b1;
                            end
                        end
                        dwell_cnt <= '0;
                        if (last_vec) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                            pass <= (mismatch_cnt == '0) && !mis_now;
                            vec  <= '0;
                        end else begin
                            vec <= vec + N_IN'(1);
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Parametrised hardware truth-table checker for N-input single-output combinational blocks. On `start` it drives every input vector 0 to 2**N_IN-1 onto the device under test and holds each one for a programmable dwell time. It samples the DUT output at the end of each dwell, builds the captured truth table and compares it against an expected table. It is the synthesisable, self-checking successor to hand-written exhaustive stimulus benches and sits between the lab top level and any boolean-expression module.

## Interface
- `N_IN`, 3: number of DUT inputs; legal range 1..8.
- `DWELL`, 4: clock cycles each vector is held; legal range 1..255.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a sweep; accepted only in IDLE.
- `abort`  in  1  cancel a running sweep.
- `expected`  in  2**N_IN  expected table; bit i is the expected output for vector i. Latched on an accepted start.
- `dut_y`  in  1  DUT output.
- `vec`  out  N_IN  DUT input vector; MSB is the first input (a).
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse when a sweep completes.
- `pass`  out  1  table matched on the last completed sweep.
- `table_out`  out  2**N_IN  captured table; bit i is `dut_y` sampled for vector i.
- `mismatch_cnt`  out  N_IN+1  number of mismatching vectors.
- `err_valid`  out  1  at least one mismatch was recorded.
- `first_err`  out  N_IN  lowest vector index that mismatched.

## Operation
- States:
  - IDLE: waiting for a start.
  - RUN: driving vectors and sampling.
- Priority: `rst` > `abort` > `start`.
- Reset: all outputs are 0, the state is IDLE, and the dwell counter is 0.
- Accepted start (IDLE and `start`=1):
  - latch `expected`;
  - clear `table_out`, `mismatch_cnt`, `err_valid`, `first_err` and `pass`;
  - set `vec`=0, dwell counter=0, `busy`=1, state RUN.
- A `start` asserted in RUN is ignored. It is not queued.
- RUN, each cycle: the dwell counter increments. When the counter equals DWELL-1 (the sample edge):
  - `table_out[vec]` <= `dut_y`;
  - on a mismatch with the latched expected bit:
    - `mismatch_cnt` increments;
    - if `err_valid`=0, then `first_err` <= `vec` and `err_valid` <= 1;
  - if `vec` == 2**N_IN-1:
    - go to IDLE with `busy`=0 and `done`=1;
    - `pass` <= 1 if the final mismatch count, including this sample, is 0;
    - `vec` returns to 0;
  - otherwise `vec` increments and the dwell counter returns to 0.
- `abort` in RUN:
  - go to IDLE with `busy`=0 and `vec`=0;
  - no `done` pulse;
  - `pass`=0;
  - partial results remain visible but are not valid.
- `abort` in IDLE has no effect.
- Results hold until the next accepted start or reset.
- `mismatch_cnt` is N_IN+1 bits wide, so the all-mismatch count 2**N_IN does not wrap.

## Timing
- Start accepted at edge E0: `vec`=0 is valid from E0.
- Vector k is driven during cycles E0+k·DWELL through E0+(k+1)·DWELL-1.
- Vector k is sampled at edge E0+(k+1)·DWELL, which captures `dut_y` from the final cycle of that dwell.
- The DUT must settle within DWELL cycles. With DWELL=1 the DUT must be purely combinational and settle within one clock period.
- `done` is high for exactly the one cycle following edge E0+2**N_IN·DWELL. `busy` falls at the same edge.
- A start asserted during the `done` cycle is accepted, because the block is in IDLE. Results are then cleared at the next edge.
- Total sweep length is 2**N_IN·DWELL cycles. The default is 32 cycles.
- `rst` mid-sweep: at the next edge every output is 0 and there is no `done` pulse.
- `abort` takes effect at the next edge.

## Test plan
1. Reset: assert `rst` for 2 cycles. Required: `vec`=0, `busy`=0, `done`=0, `pass`=0, `table_out`=0, `mismatch_cnt`=0, `err_valid`=0, `first_err`=0.
2. Defaults; the DUT model is y=(a&b)|~c; `expected`=8'hD5; pulse `start`. Required: `vec` steps 0..7 with 4 cycles per value; `done` rises 32 cycles after the start edge; `table_out`=8'hD5, `pass`=1, `mismatch_cnt`=0, `err_valid`=0.
3. Same DUT model; `expected`=8'hD4. Required: `pass`=0, `mismatch_cnt`=1, `err_valid`=1, `first_err`=0, `table_out`=8'hD5.
4. `dut_y` tied to 0; `expected`=8'hD5. Required: `table_out`=8'h00, `mismatch_cnt`=5, `first_err`=0, `pass`=0. With `expected`=8'h00 instead, `pass`=1.
5. Start the scenario 2 sweep, re-pulse `start` at cycle 5, then assert `abort` at cycle 10. Required: the re-start is ignored and `vec` sequencing is unaffected. After the abort edge, `busy`=0, `vec`=0, `pass`=0, and no `done` pulse appears. A new `start` then produces a full 32-cycle sweep.
6. With N_IN=3 and DWELL=1, assert `rst` at cycle 4 of a sweep and then restart. Required: all outputs are 0 after the reset edge. The restarted sweep asserts `done` 8 cycles after its start edge, with the correct `table_out`.
